// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Sequences the DECODE/EX and EX/MEM pipeline registers around the execution
//   block. It handles three kinds of hazard:
//     - load-use hazards that forwarding cannot cover: a one-cycle bubble;
//     - data-memory wait states: all stages are held;
//     - taken branches: a multi-cycle flush of FETCH/DECODE.
//   It also keeps saturating stall/flush performance counters.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   is_valid_DECODE_i, reg_N_*     decode-stage validity and source operands
//   *_EX_i                         execute-stage validity, load, writeback, dest, branch
//   mem_access_MEM_i, mem_ready_i  memory-stage access and completion
//   stall_*_o, bubble_execute_o    pipeline hold / invalidate controls
//   pc_load_o, flush_o             branch redirect and FETCH/DECODE invalidate
//   state_o                        0=RUN, 1=FLUSH, 2=MEM_WAIT
//   stall_cycles_o, flush_events_o saturating performance counters
module pipeline_hazard_controller #(
    parameter int ADDR_WIDTH   = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  is_valid_DECODE_i,
    input  logic                  reg_1_used_i,
    input  logic                  reg_2_used_i,
    input  logic                  reg_3_used_i,
    input  logic [ADDR_WIDTH-1:0] reg_1_source_addr_i,
    input  logic [ADDR_WIDTH-1:0] reg_2_source_addr_i,
    input  logic [ADDR_WIDTH-1:0] reg_3_source_addr_i,
    input  logic                  is_valid_EX_i,
    input  logic                  load_EX_i,
    input  logic                  reg_file_write_en_EX_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_EX_i,
    input  logic                  branch_taken_EX_i,
    input  logic                  mem_access_MEM_i,
    input  logic                  mem_ready_i,
    output logic                  stall_fetch_o,
    output logic                  stall_decode_o,
    output logic                  bubble_execute_o,
    output logic                  stall_execute_o,
    output logic                  stall_memory_o,
    output logic                  pc_load_o,
    output logic                  flush_o,
    output logic [1:0]            state_o,
    output logic [CNT_WIDTH-1:0]  stall_cycles_o,
    output logic [CNT_WIDTH-1:0]  flush_events_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 ret_flush_q, ret_flush_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_WIDTH-1:0] flush_events_q, flush_events_d;

    logic mem_wait;
    logic branch;
    logic src_hit;
    logic load_use;
    logic eff_flush;

    assign mem_wait = mem_access_MEM_i & ~mem_ready_i;
    assign branch   = is_valid_EX_i & branch_taken_EX_i;
    assign src_hit  = (reg_1_used_i & (reg_1_source_addr_i == reg_dest_EX_i))
                    | (reg_2_used_i & (reg_2_source_addr_i == reg_dest_EX_i))
                    | (reg_3_used_i & (reg_3_source_addr_i == reg_dest_EX_i));
    assign load_use = is_valid_EX_i & load_EX_i & reg_file_write_en_EX_i
                    & is_valid_DECODE_i & src_hit;

    // On the ready cycle that leaves MEM_WAIT the controller already behaves as
    // the state it returns to, so a held branch or resumed flush acts at once.
    assign eff_flush = (state_q == ST_FLUSH)
                     | ((state_q == ST_MEM_WAIT) & ret_flush_q);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            ret_flush_q    <= 1'b0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ret_flush_q    <= ret_flush_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ret_flush_d = 1'b0;
        if (mem_wait) begin
            // The flush count is frozen while waiting.
            state_d     = ST_MEM_WAIT;
            ret_flush_d = eff_flush;
        end else if (eff_flush) begin
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
        end else if (branch) begin
            cnt_d   = FLUSH_LOAD;
            state_d = (FLUSH_LOAD != 3'd0) ? ST_FLUSH : ST_RUN;
        end else begin
            state_d = ST_RUN;
        end
    end

    // Output logic
    always_comb begin
        stall_fetch_o    = 1'b0;
        stall_decode_o   = 1'b0;
        bubble_execute_o = 1'b0;
        stall_execute_o  = 1'b0;
        stall_memory_o   = 1'b0;
        pc_load_o        = 1'b0;
        flush_o          = 1'b0;
        if (!reset_i) begin
            if (mem_wait) begin
                stall_fetch_o   = 1'b1;
                stall_decode_o  = 1'b1;
                stall_execute_o = 1'b1;
                stall_memory_o  = 1'b1;
            end else if (eff_flush) begin
                flush_o          = 1'b1;
                bubble_execute_o = 1'b1;
            end else if (branch) begin
                pc_load_o        = 1'b1;
                flush_o          = 1'b1;
                bubble_execute_o = 1'b1;
            end else if (load_use) begin
                stall_fetch_o    = 1'b1;
                stall_decode_o   = 1'b1;
                bubble_execute_o = 1'b1;
            end
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (stall_fetch_o && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end
        if (pc_load_o && (flush_events_q != '1)) begin
            flush_events_d = flush_events_q + CNT_WIDTH'(1);
        end
    end

    assign state_o        = state_q;
    assign stall_cycles_o = stall_cycles_q;
    assign flush_events_o = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
//   Directed-vector bench. Three instances share one set of inputs:
//     - u_dut:  default parameters (FLUSH_CYCLES=2);
//     - u_dut3: FLUSH_CYCLES=3;
//     - u_dut4: CNT_WIDTH=4.
//   Control outputs are packed as
//   {stall_fetch, stall_decode, bubble, stall_execute, stall_memory, pc_load, flush}.
module tb_pipeline_hazard_controller;

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_LU    = 7'b1110000;
    localparam logic [6:0] C_MW    = 7'b1101100;
    localparam logic [6:0] C_BR    = 7'b0010011;
    localparam logic [6:0] C_FL    = 7'b0010001;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       is_valid_DECODE_i;
    logic       reg_1_used_i, reg_2_used_i, reg_3_used_i;
    logic [3:0] reg_1_source_addr_i, reg_2_source_addr_i, reg_3_source_addr_i;
    logic       is_valid_EX_i, load_EX_i, reg_file_write_en_EX_i;
    logic [3:0] reg_dest_EX_i;
    logic       branch_taken_EX_i, mem_access_MEM_i, mem_ready_i;

    logic [6:0]  ctrl_a, ctrl_b, ctrl_c;
    logic [1:0]  state_a, state_b, state_c;
    logic [15:0] stall_a, flush_ev_a, stall_b, flush_ev_b;
    logic [3:0]  stall_c, flush_ev_c;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_stall = 0;
    int unsigned exp_flush = 0;
    int unsigned flush_seen = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller u_dut (
        .clk_i(clk), .reset_i(reset_i), .is_valid_DECODE_i(is_valid_DECODE_i),
        .reg_1_used_i(reg_1_used_i), .reg_2_used_i(reg_2_used_i), .reg_3_used_i(reg_3_used_i),
        .reg_1_source_addr_i(reg_1_source_addr_i), .reg_2_source_addr_i(reg_2_source_addr_i),
        .reg_3_source_addr_i(reg_3_source_addr_i), .is_valid_EX_i(is_valid_EX_i),
        .load_EX_i(load_EX_i), .reg_file_write_en_EX_i(reg_file_write_en_EX_i),
        .reg_dest_EX_i(reg_dest_EX_i), .branch_taken_EX_i(branch_taken_EX_i),
        .mem_access_MEM_i(mem_access_MEM_i), .mem_ready_i(mem_ready_i),
        .stall_fetch_o(ctrl_a[6]), .stall_decode_o(ctrl_a[5]), .bubble_execute_o(ctrl_a[4]),
        .stall_execute_o(ctrl_a[3]), .stall_memory_o(ctrl_a[2]), .pc_load_o(ctrl_a[1]),
        .flush_o(ctrl_a[0]), .state_o(state_a), .stall_cycles_o(stall_a),
        .flush_events_o(flush_ev_a)
    );

    pipeline_hazard_controller #(.FLUSH_CYCLES(3)) u_dut3 (
        .clk_i(clk), .reset_i(reset_i), .is_valid_DECODE_i(is_valid_DECODE_i),
        .reg_1_used_i(reg_1_used_i), .reg_2_used_i(reg_2_used_i), .reg_3_used_i(reg_3_used_i),
        .reg_1_source_addr_i(reg_1_source_addr_i), .reg_2_source_addr_i(reg_2_source_addr_i),
        .reg_3_source_addr_i(reg_3_source_addr_i), .is_valid_EX_i(is_valid_EX_i),
        .load_EX_i(load_EX_i), .reg_file_write_en_EX_i(reg_file_write_en_EX_i),
        .reg_dest_EX_i(reg_dest_EX_i), .branch_taken_EX_i(branch_taken_EX_i),
        .mem_access_MEM_i(mem_access_MEM_i), .mem_ready_i(mem_ready_i),
        .stall_fetch_o(ctrl_b[6]), .stall_decode_o(ctrl_b[5]), .bubble_execute_o(ctrl_b[4]),
        .stall_execute_o(ctrl_b[3]), .stall_memory_o(ctrl_b[2]), .pc_load_o(ctrl_b[1]),
        .flush_o(ctrl_b[0]), .state_o(state_b), .stall_cycles_o(stall_b),
        .flush_events_o(flush_ev_b)
    );

    pipeline_hazard_controller #(.CNT_WIDTH(4)) u_dut4 (
        .clk_i(clk), .reset_i(reset_i), .is_valid_DECODE_i(is_valid_DECODE_i),
        .reg_1_used_i(reg_1_used_i), .reg_2_used_i(reg_2_used_i), .reg_3_used_i(reg_3_used_i),
        .reg_1_source_addr_i(reg_1_source_addr_i), .reg_2_source_addr_i(reg_2_source_addr_i),
        .reg_3_source_addr_i(reg_3_source_addr_i), .is_valid_EX_i(is_valid_EX_i),
        .load_EX_i(load_EX_i), .reg_file_write_en_EX_i(reg_file_write_en_EX_i),
        .reg_dest_EX_i(reg_dest_EX_i), .branch_taken_EX_i(branch_taken_EX_i),
        .mem_access_MEM_i(mem_access_MEM_i), .mem_ready_i(mem_ready_i),
        .stall_fetch_o(ctrl_c[6]), .stall_decode_o(ctrl_c[5]), .bubble_execute_o(ctrl_c[4]),
        .stall_execute_o(ctrl_c[3]), .stall_memory_o(ctrl_c[2]), .pc_load_o(ctrl_c[1]),
        .flush_o(ctrl_c[0]), .state_o(state_c), .stall_cycles_o(stall_c),
        .flush_events_o(flush_ev_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        is_valid_DECODE_i      = 1'b0;
        reg_1_used_i           = 1'b0;
        reg_2_used_i           = 1'b0;
        reg_3_used_i           = 1'b0;
        reg_1_source_addr_i    = 4'd0;
        reg_2_source_addr_i    = 4'd0;
        reg_3_source_addr_i    = 4'd0;
        is_valid_EX_i          = 1'b0;
        load_EX_i              = 1'b0;
        reg_file_write_en_EX_i = 1'b0;
        reg_dest_EX_i          = 4'd0;
        branch_taken_EX_i      = 1'b0;
        mem_access_MEM_i       = 1'b0;
        mem_ready_i            = 1'b0;
    endtask

    // Load r3 in EX; decode reads r5 on reg_1 and r3 on reg_2.
    task automatic set_load_use(input logic used2);
        is_valid_EX_i          = 1'b1;
        load_EX_i              = 1'b1;
        reg_file_write_en_EX_i = 1'b1;
        reg_dest_EX_i          = 4'd3;
        is_valid_DECODE_i      = 1'b1;
        reg_1_used_i           = 1'b1;
        reg_1_source_addr_i    = 4'd5;
        reg_2_used_i           = used2;
        reg_2_source_addr_i    = 4'd3;
    endtask

    initial begin
        clear_inputs();

        // Reset
        reset_i = 1'b1;
        set_load_use(1'b1);
        #1;
        check("rst_ctrl", 32'(ctrl_a), 32'(C_NONE));
        tick();
        clear_inputs();
        #1;
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_stall_cnt", 32'(stall_a), 32'd0);
        check("rst_flush_cnt", 32'(flush_ev_a), 32'd0);
        reset_i = 1'b0;
        tick();

        // Load-use hazard on reg_2: one bubble cycle
        set_load_use(1'b1);
        #1;
        check("lu_ctrl", 32'(ctrl_a), 32'(C_LU));
        check("lu_state", 32'(state_a), 32'd0);
        tick();
        exp_stall++;
        clear_inputs();
        #1;
        check("lu_after_ctrl", 32'(ctrl_a), 32'(C_NONE));
        check("lu_stall_cnt", 32'(stall_a), 32'(exp_stall));

        // Same pattern with reg_2 not used: no hazard
        set_load_use(1'b0);
        #1;
        check("lu_unused_ctrl", 32'(ctrl_a), 32'(C_NONE));
        // Decode invalid: no hazard
        set_load_use(1'b1);
        is_valid_DECODE_i = 1'b0;
        #1;
        check("lu_dec_invalid", 32'(ctrl_a), 32'(C_NONE));
        // Not a load: forwarding covers it
        is_valid_DECODE_i = 1'b1;
        load_EX_i = 1'b0;
        #1;
        check("lu_not_load", 32'(ctrl_a), 32'(C_NONE));
        // Match on reg_3
        clear_inputs();
        set_load_use(1'b0);
        reg_3_used_i = 1'b1;
        reg_3_source_addr_i = 4'd3;
        #1;
        check("lu_reg3_ctrl", 32'(ctrl_a), 32'(C_LU));
        tick();
        exp_stall++;
        clear_inputs();

        // Taken branch (cycle N), branch left asserted during FLUSH to check it is ignored
        is_valid_EX_i = 1'b1;
        branch_taken_EX_i = 1'b1;
        #1;
        check("br_ctrl_n", 32'(ctrl_a), 32'(C_BR));
        tick();
        exp_flush++;
        #1;
        check("br_state_n1", 32'(state_a), 32'd1);
        check("br_ctrl_n1", 32'(ctrl_a), 32'(C_FL));
        tick();
        clear_inputs();
        #1;
        check("br_state_n2", 32'(state_a), 32'd0);
        check("br_ctrl_n2", 32'(ctrl_a), 32'(C_NONE));
        check("br_flush_cnt", 32'(flush_ev_a), 32'(exp_flush));
        tick();
        tick();
        tick();
        check("br_dut3_idle", 32'(state_b), 32'd0);

        // Memory wait of 3 cycles
        mem_access_MEM_i = 1'b1;
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_ctrl", 32'(ctrl_a), 32'(C_MW));
            tick();
            exp_stall++;
            check("mw_state", 32'(state_a), 32'd2);
        end
        mem_ready_i = 1'b1;
        #1;
        check("mw_ready_ctrl", 32'(ctrl_a), 32'(C_NONE));
        tick();
        clear_inputs();
        #1;
        check("mw_exit_state", 32'(state_a), 32'd0);
        check("mw_stall_cnt", 32'(stall_a), 32'(exp_stall));

        // Branch plus load-use hazard held behind a 2-cycle memory wait
        set_load_use(1'b1);
        branch_taken_EX_i = 1'b1;
        mem_access_MEM_i = 1'b1;
        mem_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("sim_wait_ctrl", 32'(ctrl_a), 32'(C_MW));
            tick();
            exp_stall++;
        end
        mem_ready_i = 1'b1;
        #1;
        check("sim_ready_ctrl", 32'(ctrl_a), 32'(C_BR));
        tick();
        exp_flush++;
        clear_inputs();
        #1;
        check("sim_state", 32'(state_a), 32'd1);
        check("sim_flush_cnt", 32'(flush_ev_a), 32'(exp_flush));
        check("sim_stall_cnt", 32'(stall_a), 32'(exp_stall));
        tick();
        tick();
        tick();
        check("sim_dut3_idle", 32'(state_b), 32'd0);

        // FLUSH_CYCLES=3 with a memory wait in the second flush cycle
        flush_seen = 0;
        is_valid_EX_i = 1'b1;
        branch_taken_EX_i = 1'b1;
        #1;
        check("wf_ctrl_n", 32'(ctrl_b), 32'(C_BR));
        flush_seen += 32'(ctrl_b[0]);
        tick();
        exp_flush++;
        clear_inputs();
        mem_access_MEM_i = 1'b1;
        #1;
        check("wf_state_n1", 32'(state_b), 32'd1);
        check("wf_wait_ctrl", 32'(ctrl_b), 32'(C_MW));
        flush_seen += 32'(ctrl_b[0]);
        tick();
        exp_stall++;
        check("wf_wait_state", 32'(state_b), 32'd2);
        mem_ready_i = 1'b1;
        #1;
        check("wf_ready_ctrl", 32'(ctrl_b), 32'(C_FL));
        flush_seen += 32'(ctrl_b[0]);
        tick();
        clear_inputs();
        #1;
        check("wf_resume_state", 32'(state_b), 32'd1);
        check("wf_last_ctrl", 32'(ctrl_b), 32'(C_FL));
        flush_seen += 32'(ctrl_b[0]);
        tick();
        check("wf_done_state", 32'(state_b), 32'd0);
        check("wf_flush_total", flush_seen, 32'd3);
        check("wf_flush_cnt", 32'(flush_ev_b), 32'(exp_flush));

        // Reset in the middle of FLUSH
        is_valid_EX_i = 1'b1;
        branch_taken_EX_i = 1'b1;
        tick();
        clear_inputs();
        check("rf_state_flush", 32'(state_a), 32'd1);
        reset_i = 1'b1;
        #1;
        check("rf_ctrl", 32'(ctrl_a), 32'(C_NONE));
        tick();
        reset_i = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        check("rf_state", 32'(state_a), 32'd0);
        check("rf_flush_cnt", 32'(flush_ev_a), 32'd0);

        // Saturation: 2^4+5 stall cycles on the 4-bit counter
        mem_access_MEM_i = 1'b1;
        mem_ready_i = 1'b0;
        for (int i = 0; i < 21; i++) begin
            tick();
            exp_stall++;
            if (i == 14) check("sat_at_15", 32'(stall_c), 32'd15);
        end
        check("sat_hold_15", 32'(stall_c), 32'd15);
        check("sat_wide_cnt", 32'(stall_a), 32'(exp_stall));
        mem_ready_i = 1'b1;
        tick();
        clear_inputs();
        check("sat_exit_state", 32'(state_c), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
